// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler: note indices, melody ROM entry
// layout, scheduler state encoding and small note helpers.
package note_pkg;

    // Note index = bit position in the one-hot note select.
    localparam int NOTE_C4 = 7;
    localparam int NOTE_D  = 6;
    localparam int NOTE_E  = 5;
    localparam int NOTE_F  = 4;
    localparam int NOTE_G  = 3;
    localparam int NOTE_A  = 2;
    localparam int NOTE_B  = 1;
    localparam int NOTE_C5 = 0;

    // ROM entry = {note_idx[2:0], dur_code[1:0]}.
    localparam int ENTRY_W  = 5;
    localparam int NOTE_MSB = 4;
    localparam int NOTE_LSB = 2;
    localparam int DUR_MSB  = 1;
    localparam int DUR_LSB  = 0;

    typedef struct packed {
        logic [NOTE_MSB-NOTE_LSB:0] note_idx;
        logic [DUR_MSB-DUR_LSB:0]   dur_code;
    } rom_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NOTE = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Builds a ROM entry from a note index and a length in beats (1..4).
    function automatic rom_entry_t make_entry(int note, int beats);
        rom_entry_t e;
        e.note_idx = 3'(note);
        e.dur_code = 2'(beats - 1);
        return e;
    endfunction

    localparam int MELODY_LEN = 15;

    localparam rom_entry_t MELODY [MELODY_LEN] = '{
        make_entry(NOTE_E, 1),  make_entry(NOTE_E, 1),  make_entry(NOTE_F, 1),
        make_entry(NOTE_G, 1),  make_entry(NOTE_G, 1),  make_entry(NOTE_F, 1),
        make_entry(NOTE_E, 1),  make_entry(NOTE_D, 1),  make_entry(NOTE_C4, 1),
        make_entry(NOTE_C4, 1), make_entry(NOTE_D, 1),  make_entry(NOTE_E, 1),
        make_entry(NOTE_E, 2),  make_entry(NOTE_D, 1),  make_entry(NOTE_D, 2)
    };

    // One-hot select for a note index.
    function automatic logic [7:0] note_onehot(logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Keeps only the lowest set bit: lowest index wins, i.e. higher pitch.
    function automatic logic [7:0] lowest_set(logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Control/status bundle between the note scheduler and its user.
interface note_scheduler_if #(
    parameter int IDX_W = 4
);
    logic [7:0]       sw;
    logic             play;
    logic             stop;
    logic             loop_en;
    logic [7:0]       note_sel;
    logic [7:0]       Led;
    logic             busy;
    logic [IDX_W-1:0] song_idx;

    modport master (
        output sw, play, stop, loop_en,
        input  note_sel, Led, busy, song_idx
    );

    modport slave (
        input  sw, play, stop, loop_en,
        output note_sel, Led, busy, song_idx
    );
endinterface

// File: rtl/note_scheduler_song_rom.sv
// Synchronous melody ROM: one registered read per cycle, zero past the song end.
module note_scheduler_song_rom
    import note_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int SONG_LEN = 15
) (
    input  logic             CLK,
    input  logic [IDX_W-1:0] i_addr,
    output rom_entry_t       o_data
);

    rom_entry_t r_data;

    // Registered table lookup.
    // NOTE: the read register carries no reset; its content is fully
    // determined by the address one cycle earlier, and the scheduler only
    // consumes it after addressing it.
    always_ff @(posedge CLK) begin
        if (int'(i_addr) < SONG_LEN && int'(i_addr) < MELODY_LEN) begin
            r_data <= MELODY[i_addr];
        end else begin
            r_data <= '0;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: arbitrates manual keys against the autoplay sequencer and
// drives a registered one-hot note select to the tone generator and LEDs.
module note_scheduler
    import note_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25,
    parameter int GAP_TICKS      = 2,
    parameter int SONG_LEN       = 15,
    parameter int IDX_W          = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    note_scheduler_if.slave   bus
);

    localparam int MAX_TICKS = (4 * TICKS_PER_BEAT > GAP_TICKS) ? 4 * TICKS_PER_BEAT : GAP_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);

    state_t           r_state;
    logic [7:0]       r_note_sel;
    logic             r_busy;
    logic [IDX_W-1:0] r_song_idx;
    logic [TICK_W-1:0] r_tick;

    state_t           w_state_nxt;
    logic [7:0]       w_note_nxt;
    logic             w_busy_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [TICK_W-1:0] w_tick_nxt;

    logic [7:0]       w_sw_sel;
    logic             w_abort;
    rom_entry_t       w_rom;
    logic [TICK_W-1:0] w_dur_ticks;

    assign w_sw_sel    = lowest_set(bus.sw);
    assign w_abort     = bus.stop || (bus.sw != 8'd0);
    // Counter runs down to zero, so it is loaded with length-1.
    assign w_dur_ticks = TICK_W'((int'(w_rom.dur_code) + 1) * TICKS_PER_BEAT - 1);

    // The ROM is addressed with the next index so the entry is already
    // registered when the FSM sits in LOAD.
    note_scheduler_song_rom #(
        .IDX_W    (IDX_W),
        .SONG_LEN (SONG_LEN)
    ) u_song_rom (
        .CLK    (CLK),
        .i_addr (w_idx_nxt),
        .o_data (w_rom)
    );

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        // NOTE: every signal gets a hold value before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_note_nxt  = r_note_sel;
        w_busy_nxt  = r_busy;
        w_idx_nxt   = r_song_idx;
        w_tick_nxt  = r_tick;

        case (r_state)
            IDLE: begin
                w_note_nxt = w_sw_sel;
                if (bus.play && !bus.stop && bus.sw == 8'd0) begin
                    w_state_nxt = LOAD;
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                end
            end

            LOAD: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = '0;
                    w_note_nxt  = w_sw_sel;
                end else begin
                    w_state_nxt = NOTE;
                    w_note_nxt  = note_onehot(w_rom.note_idx);
                    w_tick_nxt  = w_dur_ticks;
                end
            end

            NOTE: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = '0;
                    w_note_nxt  = w_sw_sel;
                end else if (r_tick == '0) begin
                    w_state_nxt = GAP;
                    w_note_nxt  = 8'd0;
                    w_tick_nxt  = TICK_W'(GAP_TICKS - 1);
                end else begin
                    w_tick_nxt  = r_tick - 1'b1;
                end
            end

            GAP: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = '0;
                    w_note_nxt  = w_sw_sel;
                end else if (r_tick != '0) begin
                    w_tick_nxt  = r_tick - 1'b1;
                end else if (r_song_idx < IDX_W'(SONG_LEN - 1)) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = r_song_idx + 1'b1;
                end else if (bus.loop_en) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = '0;
                w_tick_nxt  = '0;
                w_note_nxt  = 8'd0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!RESET) begin
            r_state    <= IDLE;
            r_note_sel <= 8'd0;
            r_busy     <= 1'b0;
            r_song_idx <= '0;
            r_tick     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_note_sel <= w_note_nxt;
            r_busy     <= w_busy_nxt;
            r_song_idx <= w_idx_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign bus.note_sel = r_note_sel;
    assign bus.Led      = r_note_sel;
    assign bus.busy     = r_busy;
    assign bus.song_idx = r_song_idx;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler with TICKS_PER_BEAT=4, GAP_TICKS=1.
module tb_note_scheduler;

    localparam int TPB      = 4;
    localparam int GAP      = 1;
    localparam int SONG_LEN = 15;

    logic clk;
    logic rst_n;

    note_scheduler_if #(.IDX_W(4)) bif ();

    note_scheduler #(
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP),
        .SONG_LEN       (SONG_LEN),
        .IDX_W          (4)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Melody as written: bit position of each note and its length in beats.
    int song_bit   [SONG_LEN] = '{5, 5, 4, 3, 3, 4, 5, 6, 7, 7, 6, 5, 5, 6, 6};
    int song_beats [SONG_LEN] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 2};

    typedef struct {
        logic [7:0] note;
        int         idx;
    } slot_t;

    // Expected per-cycle output of one song pass, starting with entry 0's LOAD.
    slot_t stream[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Manual arbitration model: scan upward from bit 0.
    function automatic logic [7:0] model_manual(logic [7:0] sw);
        for (int b = 0; b < 8; b++) begin
            if (sw[b]) return 8'd1 << b;
        end
        return 8'd0;
    endfunction

    function automatic void build_stream();
        slot_t s;
        stream.delete();
        for (int e = 0; e < SONG_LEN; e++) begin
            s.idx  = e;
            s.note = 8'd0;
            stream.push_back(s);
            s.note = 8'd1 << song_bit[e];
            for (int k = 0; k < song_beats[e] * TPB; k++) stream.push_back(s);
            s.note = 8'd0;
            for (int g = 0; g < GAP; g++) stream.push_back(s);
        end
    endfunction

    // Compares cycles 0..n-1 of the song stream, one per cycle.
    task automatic run_stream(int n, string tag);
        for (int p = 0; p < n; p++) begin
            check({tag, "_note"}, 32'(bif.note_sel), 32'(stream[p].note));
            check({tag, "_busy"}, 32'(bif.busy), 32'd1);
            check({tag, "_idx"},  32'(bif.song_idx), 32'(stream[p].idx));
            step();
        end
    endtask

    task automatic pulse_play();
        bif.play = 1'b1;
        step();
        bif.play = 1'b0;
    endtask

    task automatic check_idle(string tag, logic [7:0] exp_note);
        check({tag, "_note"}, 32'(bif.note_sel), 32'(exp_note));
        check({tag, "_led"},  32'(bif.Led), 32'(exp_note));
        check({tag, "_busy"}, 32'(bif.busy), 32'd0);
        check({tag, "_idx"},  32'(bif.song_idx), 32'd0);
    endtask

    initial begin
        logic [7:0] sw_v;
        logic [7:0] dir_sw [3];
        int pos;

        bif.sw      = 8'hFF;
        bif.play    = 1'b0;
        bif.stop    = 1'b0;
        bif.loop_en = 1'b0;
        rst_n       = 1'b0;
        build_stream();
        check("stream_len", 32'(stream.size()), 32'd98);

        // Reset held with all keys pressed keeps everything quiet.
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        check_idle("reset", 8'h00);
        rst_n = 1'b1;
        step();
        check_idle("post_reset", model_manual(8'hFF));

        // Manual priority: directed then random key patterns.
        dir_sw[0] = 8'b1010_0000;
        dir_sw[1] = 8'h80;
        dir_sw[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bif.sw = dir_sw[i];
            step();
            check_idle("manual_dir", model_manual(dir_sw[i]));
        end
        for (int i = 0; i < 16; i++) begin
            sw_v   = 8'($urandom);
            bif.sw = sw_v;
            step();
            check_idle("manual_rnd", model_manual(sw_v));
        end
        bif.sw = 8'h00;
        step();

        // Full song, no loop: LOAD cycle first, busy for exactly 98 cycles.
        pulse_play();
        run_stream(stream.size(), "song");
        check_idle("song_end", 8'h00);
        step();
        check_idle("song_end2", 8'h00);

        // Override in entry 3's NOTE phase (entry 3 LOAD sits at cycle 18).
        pulse_play();
        pos = 19 + int'($urandom_range(0, song_beats[3] * TPB - 1));
        run_stream(pos, "pre_ovr");
        bif.sw = 8'h02;
        step();
        check_idle("override", 8'h02);
        bif.play = 1'b1;
        step();
        bif.play = 1'b0;
        check_idle("play_with_sw", 8'h02);
        bif.sw = 8'h00;
        step();
        check_idle("release", 8'h00);

        // Random aborts at random points by keys or stop.
        for (int t = 0; t < 4; t++) begin
            pulse_play();
            pos = int'($urandom_range(0, 97));
            run_stream(pos, "pre_abort");
            if (t[0]) begin
                sw_v     = 8'($urandom_range(1, 255));
                bif.sw   = sw_v;
            end else begin
                sw_v     = 8'h00;
                bif.stop = 1'b1;
            end
            step();
            bif.stop = 1'b0;
            check_idle("abort", model_manual(sw_v));
            bif.sw = 8'h00;
            step();
        end

        // Stop and play together in IDLE: nothing starts.
        bif.play = 1'b1;
        bif.stop = 1'b1;
        step();
        bif.play = 1'b0;
        bif.stop = 1'b0;
        check_idle("idle_play_stop", 8'h00);

        // Loop: after entry 14's gap the song re-enters LOAD at index 0.
        bif.loop_en = 1'b1;
        pulse_play();
        run_stream(stream.size(), "loop1");
        check("loop_load_note", 32'(bif.note_sel), 32'h00);
        check("loop_load_busy", 32'(bif.busy), 32'd1);
        check("loop_load_idx",  32'(bif.song_idx), 32'd0);
        step();
        check("loop_first_note", 32'(bif.note_sel), 32'(stream[1].note));
        check("loop_first_busy", 32'(bif.busy), 32'd1);

        // Play and stop together while busy: stop wins.
        bif.play = 1'b1;
        bif.stop = 1'b1;
        step();
        bif.play = 1'b0;
        bif.stop = 1'b0;
        bif.loop_en = 1'b0;
        check_idle("busy_play_stop", 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
